// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer: sequential step, direct jump, and
// memory-indirect jump through a req/ack read with a sticky timeout fault.
module pc_sequencer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [WIDTH-1:0] PC_INC      = WIDTH'(1),
  parameter int               ACK_TIMEOUT = 15
) (
  input  logic             inClock,
  input  logic             inReset_n,
  input  logic             inSourceA,
  input  logic             inSourceB,
  input  logic [WIDTH-1:0] inTarget,
  input  logic             inStall,
  input  logic             inMemAck,
  input  logic [WIDTH-1:0] inMemData,
  output logic [WIDTH-1:0] outPC,
  output logic             outMemReq,
  output logic [WIDTH-1:0] outMemAddr,
  output logic             outRedirect,
  output logic             outBusy,
  output logic             outFault
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;
  logic               redirect_q, redirect_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    redirect_d = 1'b0;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    case (state_q)
      RUN: begin
        if (!inStall) begin
          if (inSourceB) begin
            mem_addr_d = inTarget;
            mem_req_d  = 1'b1;
            cnt_d      = '0;
            state_d    = MEM_WAIT;
          end else if (inSourceA) begin
            pc_d       = inTarget;
            redirect_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end
      end
      MEM_WAIT: begin
        // Ack is tested first so a same-edge ack beats the timeout.
        if (inMemAck) begin
          pc_d       = inMemData;
          mem_req_d  = 1'b0;
          redirect_d = 1'b1;
          state_d    = RUN;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          fault_d    = 1'b1;
          mem_req_d  = 1'b0;
          pc_d       = pc_q + PC_INC;
          redirect_d = 1'b1;
          state_d    = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge inClock or negedge inReset_n) begin
    if (!inReset_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      redirect_q <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      redirect_q <= redirect_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign outPC       = pc_q;
  assign outMemReq   = mem_req_q;
  assign outMemAddr  = mem_addr_q;
  assign outRedirect = redirect_q;
  assign outBusy     = (state_q == MEM_WAIT);
  assign outFault    = fault_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and next-PC sequencer. It consumes the two PC-source selects produced by the branch/jump resolution logic and produces the fetch address.
- Sequential increment, direct jump/branch to a register target, and memory-indirect jump (PC = Mem[target]) through a request/acknowledge handshake to data memory.
- Provides a one-cycle redirect pulse for pipeline flush, a busy flag for upstream stall, and a sticky fault on memory-handshake timeout.

Parameters:
- WIDTH, 32, PC / address / data width in bits.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 1, increment added for sequential flow.
- ACK_TIMEOUT, 15, maximum cycles spent waiting for inMemAck before faulting (must be >= 1).

Ports:
- inClock  input  1  single clock; all state updates on rising edge.
- inReset_n  input  1  asynchronous, active-low reset.
- inSourceA  input  1  select: load PC from inTarget (taken branch or jump).
- inSourceB  input  1  select: load PC from memory at inTarget (jump-memory); priority over inSourceA.
- inTarget  input  WIDTH  branch/jump target, or memory address for jump-memory.
- inStall  input  1  hold PC; selects ignored while high in RUN.
- inMemAck  input  1  memory read complete; inMemData valid this cycle.
- inMemData  input  WIDTH  memory read data.
- outPC  output  WIDTH  current fetch address (registered).
- outMemReq  output  1  memory read request (registered).
- outMemAddr  output  WIDTH  memory read address, stable while outMemReq is high.
- outRedirect  output  1  one-cycle pulse, high in the cycle after PC is loaded from a non-sequential source.
- outBusy  output  1  high while in MEM_WAIT.
- outFault  output  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, inReset_n=0):
  - outPC=RESET_PC, outMemReq=0, outMemAddr=0, outRedirect=0, outBusy=0, outFault=0.
  - Timeout counter=0, state=RUN.
  - Reset asserted mid-handshake aborts the request immediately; a late inMemAck after reset is ignored.
- States: RUN, MEM_WAIT.
- RUN, at each rising edge:
  - inStall=1: PC held, outRedirect<=0, selects ignored.
  - else inSourceB=1: PC held; outMemAddr<=inTarget; outMemReq<=1; counter<=0; state<=MEM_WAIT. inSourceA is ignored.
  - else inSourceA=1: PC<=inTarget; outRedirect<=1.
  - else: PC<=PC+PC_INC, modulo 2^WIDTH (0xFFFFFFFF+1 -> 0x00000000); outRedirect<=0.
  - inMemAck in RUN is ignored.
- MEM_WAIT:
  - outBusy=1 combinationally from state; outMemReq and outMemAddr held stable.
  - inStall, inSourceA, inSourceB and inTarget are ignored.
  - inMemAck=1 at an edge: PC<=inMemData; outMemReq<=0; outRedirect<=1; state<=RUN.
  - else if counter==ACK_TIMEOUT-1: outFault<=1 (sticky until reset); outMemReq<=0; PC<=PC+PC_INC; outRedirect<=1; state<=RUN.
  - else: counter<=counter+1.
  - inMemAck and timeout on the same edge: the ack wins and no fault is raised.
- Latency:
  - Direct redirect: new PC visible 1 cycle after the select is sampled.
  - Memory jump: outMemReq high 1 cycle after the select; PC updates on the ack edge. Minimum 2 cycles, select to new PC.
- outRedirect is high for exactly one cycle per non-sequential load; it is cleared on the next edge regardless of stall.
- Counter width is clog2(ACK_TIMEOUT)+1; it must never wrap.

Test Plan:
- Reset then 4 unstalled cycles, selects low -> outPC 0,1,2,3,4; outRedirect=0 throughout; outFault=0.
- At PC=5, inSourceA=1, inTarget=0x40 for 1 cycle -> outPC=0x40 next cycle, outRedirect pulses 1 cycle, then 0x41.
- At PC=0x41, inSourceA=1 and inSourceB=1, inTarget=0x80 -> outMemReq=1, outMemAddr=0x80, outBusy=1, outPC stays 0x41. Ack on 3rd wait cycle with inMemData=0x200 -> outPC=0x200, outRedirect pulse, outMemReq=0, outBusy=0.
- inStall=1 for 3 cycles with inSourceA=1 -> outPC unchanged. Then inStall=0 and inSourceB=1 with no ack for 15 cycles -> outFault=1, outPC=old+1, outMemReq=0. outFault stays 1 until reset.
- outPC=0xFFFFFFFF, sequential step -> outPC=0x00000000.
- inReset_n driven low while in MEM_WAIT -> outMemReq=0 and outPC=0 immediately. inMemAck pulsed after release -> ignored, PC increments normally.
